// File: rtl/image_tx_framer.sv
// Frames a raw pixel stream into AXI4-Stream video: tuser on the first pixel, tlast on each line end.
// Optional IMG_FRAMER_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module image_tx_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 12
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  ctl_start,
    input  logic [DIM_WIDTH-1:0]  ctl_width,
    input  logic [DIM_WIDTH-1:0]  ctl_height,
    output logic                  ctl_busy,
    output logic                  ctl_done,
    input  logic [DATA_WIDTH-1:0] s_pix_tdata,
    input  logic                  s_pix_tvalid,
    output logic                  s_pix_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast
`ifdef IMG_FRAMER_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    state_t               state, state_nxt;
    logic [DIM_WIDTH-1:0] width_q, height_q, x_q, y_q;
    logic                 in_hs, out_hs, x_last, y_last, start_ok;

    assign in_hs    = s_pix_tvalid & s_pix_tready;
    assign out_hs   = m_axis_tvalid & m_axis_tready;
    assign x_last   = (x_q == (width_q - DIM_ONE));
    assign y_last   = (y_q == (height_q - DIM_ONE));
    assign start_ok = ctl_start && (ctl_width != '0) && (ctl_height != '0);

    assign s_pix_tready = (state == ACTIVE) && (!m_axis_tvalid || m_axis_tready);
    assign ctl_busy     = (state != IDLE);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = ACTIVE;
            ACTIVE:  if (in_hs && x_last && y_last) state_nxt = DRAIN;
            DRAIN:   if (out_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            width_q       <= '0;
            height_q      <= '0;
            x_q           <= '0;
            y_q           <= '0;
            ctl_done      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            // A zero-sized start completes immediately without entering ACTIVE.
            if (state == IDLE && ctl_start) begin
                width_q  <= ctl_width;
                height_q <= ctl_height;
                x_q      <= '0;
                y_q      <= '0;
                ctl_done <= !start_ok;
            end
            if (in_hs) begin
                m_axis_tdata <= s_pix_tdata;
                m_axis_tuser <= (x_q == '0) && (y_q == '0);
                m_axis_tlast <= x_last;
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_q + DIM_ONE;
                end else begin
                    x_q <= x_q + DIM_ONE;
                end
            end
            if (in_hs)       m_axis_tvalid <= 1'b1;
            else if (out_hs) m_axis_tvalid <= 1'b0;
            if (state == DRAIN && out_hs) ctl_done <= 1'b1;
        end
    end

`ifdef IMG_FRAMER_FRAME_CNT_EN
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                        frame_cnt <= '0;
        else if (state == DRAIN && out_hs) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/image_tx_framer.md
IMAGE_TX_FRAMER -- requirements
Module: image_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning pixel bus width in bits.
REQ-002 SHALL have parameter DIM_WIDTH, default 12, meaning width of the frame width and height fields.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port ARESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ctl_start, input, 1, one-cycle start pulse from the image_ctl register block.
REQ-006 SHALL have port ctl_width, input, DIM_WIDTH, pixels per line.
REQ-007 SHALL have port ctl_height, input, DIM_WIDTH, lines per frame.
REQ-008 SHALL have port ctl_busy, output, 1, frame in progress.
REQ-009 SHALL have port ctl_done, output, 1, sticky frame-complete flag.
REQ-010 SHALL have ports s_pix_tdata (input, DATA_WIDTH), s_pix_tvalid (input, 1) and s_pix_tready (output, 1), the raw pixel input.
REQ-011 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tuser (output, 1, start of frame) and m_axis_tlast (output, 1, end of line), the AXI4-Stream video output.
REQ-012 SHALL have port frame_cnt, output, 16, completed-frame count, present only under IMG_FRAMER_FRAME_CNT_EN.

Function
REQ-013 SHALL implement the FSM states IDLE, ACTIVE and DRAIN.
REQ-014 SHALL, in IDLE with ctl_start=1, latch ctl_width/ctl_height, clear the x/y counters, clear ctl_done and enter ACTIVE next cycle.
REQ-015 SHALL, when ctl_start=1 with latched width=0 or height=0, skip ACTIVE, set ctl_done next cycle, emit no beats and stay in IDLE.
REQ-016 SHALL ignore ctl_start in ACTIVE or DRAIN; latched dimensions do not change mid-frame.
REQ-017 SHALL hold ctl_busy=1 exactly while the state is ACTIVE or DRAIN.
REQ-018 SHALL drive s_pix_tready = (state==ACTIVE) AND (m_axis_tvalid==0 OR m_axis_tready==1), combinationally.
REQ-019 SHALL, on an input handshake, load the registered output stage with data, tuser=(x==0 AND y==0) and tlast=(x==width-1), and set m_axis_tvalid on the next cycle; latency is 1 cycle.
REQ-020 SHALL clear m_axis_tvalid on an output handshake unless a new input handshake occurs in the same cycle; a simultaneous input and output handshake gives back-to-back beats with no bubble.
REQ-021 SHALL hold m_axis_tdata, m_axis_tuser and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 SHALL increment x per input handshake; at x==width-1, x wraps to 0 and y increments.
REQ-023 SHALL, on accepting the pixel x==width-1 and y==height-1, enter DRAIN.
REQ-024 SHALL, in DRAIN on the output handshake of the final beat, set ctl_done=1 and return to IDLE in the next cycle.
REQ-025 SHALL keep ctl_done at 1 until the next accepted ctl_start.
REQ-026 SHALL compare counters at DIM_WIDTH bits; width/height maximum is 2^DIM_WIDTH-1.

Reset
REQ-027 SHALL, while ARESET=1 (asynchronous), force IDLE, x=y=0, m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0, ctl_busy=0, ctl_done=0, latched dims=0 and frame_cnt=0.
REQ-028 SHALL, when ARESET is asserted mid-frame, discard the partial frame; after release the block is IDLE and emits nothing until a new ctl_start.

Configuration
REQ-029 SHALL, with IMG_FRAMER_FRAME_CNT_EN defined, provide frame_cnt, which increments by 1 (wrapping at 16'hFFFF to 0) in the cycle ctl_done is set by REQ-024; zero-dimension starts do not count.
REQ-030 SHALL, without IMG_FRAMER_FRAME_CNT_EN, omit the frame_cnt port and its counter; all other behaviour is identical.

Verification
REQ-031 SHALL cover this scenario: width=4, height=2, source always valid, sink always ready -> 8 beats on consecutive cycles; tuser on beat 0 only; tlast on beats 3 and 7; ctl_done=1 one cycle after beat 7.
REQ-032 SHALL cover this scenario: width=3, height=1, m_axis_tready toggling 1010... -> data order preserved; payload stable while stalled; s_pix_tready=0 while the output is full and not ready.
REQ-033 SHALL cover this scenario: ctl_start with width=0, height=5 -> no m_axis_tvalid; ctl_done=1 next cycle; ctl_busy stays 0.
REQ-034 SHALL cover this scenario: ctl_start pulsed again mid-frame (width=4, height=2) -> ignored; the frame completes with exactly 8 beats.
REQ-035 SHALL cover this scenario: ARESET asserted after the 3rd beat of a 4x2 frame, then a new 2x1 start -> the outputs reset immediately; the new frame gives 2 beats with tuser on the first and tlast on the second.
REQ-036 SHALL cover this scenario: with IMG_FRAMER_FRAME_CNT_EN, three consecutive 2x2 frames -> frame_cnt=3; a zero-dimension start leaves it at 3.
